// File: rtl/pll_mode_ctrl_pkg.sv
// pll_mode_ctrl_pkg: shared types and helpers for the rPLL mode supervisor.
package pll_mode_ctrl_pkg;

  // Width of each rPLL dynamic divider select bus
  localparam int SEL_W = 6;

  // Supervisor sequencing states
  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_WAIT_LOCK  = 2'd1,
    ST_LOCKED     = 2'd2,
    ST_FAULT      = 2'd3
  } state_e;

  // Gowin dynamic selects take the complement of the static divider setting
  function automatic logic [SEL_W-1:0] sel_encode(input logic [SEL_W-1:0] raw);
    return ~raw;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parametrised-width double-flop synchroniser, clears to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_mode_ctrl.sv
// pll_mode_ctrl: drives rPLL divider selects from a preset table, sequences
// the PLL reset, filters LOCK and releases the downstream video reset.
module pll_mode_ctrl
  import pll_mode_ctrl_pkg::*;
#(
  parameter int                       N_MODES      = 4,
  parameter logic [SEL_W*N_MODES-1:0] IDIV_TABLE   = '0,
  parameter logic [SEL_W*N_MODES-1:0] FBDIV_TABLE  = '0,
  parameter logic [SEL_W*N_MODES-1:0] ODIV_TABLE   = '0,
  parameter int                       DEFAULT_MODE = 0,
  parameter int                       RESET_CYCLES = 16,
  parameter int                       LOCK_FILTER  = 1024,
  parameter int                       LOCK_TIMEOUT = 65536,
  parameter int                       MAX_RETRY    = 3,
  localparam int                      MW = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pll_lock,
  output logic             pll_rst,
  output logic [SEL_W-1:0] pll_idsel,
  output logic [SEL_W-1:0] pll_fbdsel,
  output logic [SEL_W-1:0] pll_odsel,
  input  logic [MW-1:0]    mode_sel,
  input  logic             mode_valid,
  output logic             mode_ready,
  output logic [MW-1:0]    mode_cur,
  output logic             mode_err,
  output logic             locked,
  output logic             fault,
  output logic             video_resetn
);

  localparam int RCW = $clog2(RESET_CYCLES) + 1;
  localparam int FCW = $clog2(LOCK_FILTER) + 1;
  localparam int TCW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int YCW = $clog2(MAX_RETRY) + 1;

  localparam logic [RCW-1:0]   RST_LAST  = RCW'(RESET_CYCLES - 1);
  localparam logic [FCW-1:0]   FILT_LAST = FCW'(LOCK_FILTER - 1);
  localparam logic [TCW-1:0]   TMO_LAST  = TCW'(LOCK_TIMEOUT - 1);
  localparam logic [YCW-1:0]   RETRY_MAX = YCW'(MAX_RETRY);
  localparam logic [MW:0]      N_MODES_W = (MW + 1)'(N_MODES);
  localparam logic [MW-1:0]    DEF_MODE  = MW'(DEFAULT_MODE);
  localparam logic [SEL_W-1:0] DEF_ID    = sel_encode(IDIV_TABLE[DEFAULT_MODE*SEL_W +: SEL_W]);
  localparam logic [SEL_W-1:0] DEF_FB    = sel_encode(FBDIV_TABLE[DEFAULT_MODE*SEL_W +: SEL_W]);
  localparam logic [SEL_W-1:0] DEF_OD    = sel_encode(ODIV_TABLE[DEFAULT_MODE*SEL_W +: SEL_W]);

  state_e           state_q;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [FCW-1:0]   filt_cnt_q, filt_cnt_d;
  logic [TCW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [YCW-1:0]   retry_q, retry_d;
  logic [MW-1:0]    mode_cur_q;
  logic [SEL_W-1:0] idsel_q, fbdsel_q, odsel_q;
  logic             pll_rst_q, locked_q, fault_q, video_resetn_q, mode_ready_q, mode_err_q;

  logic             lock_s;
  logic             req_accept_s, req_good_s, req_bad_s;
  logic [MW-1:0]    lookup_mode_s;
  logic [SEL_W-1:0] id_raw_s, fb_raw_s, od_raw_s;
  logic             lock_done_s, tmo_done_s, rh_entry_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d_i    (pll_lock),
    .q_o    (lock_s)
  );

  // Saturating next values of the sequencing counters
  always_comb begin
    rst_cnt_d  = (rst_cnt_q  == {RCW{1'b1}}) ? rst_cnt_q  : rst_cnt_q  + RCW'(1);
    filt_cnt_d = (filt_cnt_q == {FCW{1'b1}}) ? filt_cnt_q : filt_cnt_q + FCW'(1);
    tmo_cnt_d  = (tmo_cnt_q  == {TCW{1'b1}}) ? tmo_cnt_q  : tmo_cnt_q  + TCW'(1);
    retry_d    = (retry_q    == {YCW{1'b1}}) ? retry_q    : retry_q    + YCW'(1);
  end

  // Request decode and preset table lookup for the mode about to be applied
  always_comb begin
    req_accept_s  = mode_valid & mode_ready_q;
    req_good_s    = req_accept_s & ({1'b0, mode_sel} < N_MODES_W);
    req_bad_s     = req_accept_s & ~({1'b0, mode_sel} < N_MODES_W);
    lookup_mode_s = req_good_s ? mode_sel : mode_cur_q;
    id_raw_s      = '0;
    fb_raw_s      = '0;
    od_raw_s      = '0;
    for (int i = 0; i < N_MODES; i++) begin
      id_raw_s = id_raw_s | (IDIV_TABLE[i*SEL_W +: SEL_W]  & {SEL_W{lookup_mode_s == MW'(i)}});
      fb_raw_s = fb_raw_s | (FBDIV_TABLE[i*SEL_W +: SEL_W] & {SEL_W{lookup_mode_s == MW'(i)}});
      od_raw_s = od_raw_s | (ODIV_TABLE[i*SEL_W +: SEL_W]  & {SEL_W{lookup_mode_s == MW'(i)}});
    end
  end

  // Decide whether this edge (re)starts the PLL reset sequence
  always_comb begin
    lock_done_s = lock_s && (filt_cnt_q == FILT_LAST);
    tmo_done_s  = (tmo_cnt_q == TMO_LAST);
    rh_entry_s  = 1'b0;
    case (state_q)
      ST_WAIT_LOCK: rh_entry_s = !lock_done_s && tmo_done_s && (retry_d < RETRY_MAX);
      ST_LOCKED:    rh_entry_s = req_good_s || !lock_s;
      ST_FAULT:     rh_entry_s = req_good_s;
      default:      rh_entry_s = 1'b0;
    endcase
  end

  // Supervisor FSM with registered PLL controls and status outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_RESET_HOLD;
      rst_cnt_q      <= '0;
      filt_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
      retry_q        <= '0;
      mode_cur_q     <= DEF_MODE;
      idsel_q        <= DEF_ID;
      fbdsel_q       <= DEF_FB;
      odsel_q        <= DEF_OD;
      pll_rst_q      <= 1'b1;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
      video_resetn_q <= 1'b0;
      mode_ready_q   <= 1'b0;
      mode_err_q     <= 1'b0;
    end else begin
      mode_err_q <= req_bad_s;
      if (rh_entry_s) begin
        // New divider settings are latched only while the PLL is held in reset
        state_q        <= ST_RESET_HOLD;
        rst_cnt_q      <= '0;
        idsel_q        <= sel_encode(id_raw_s);
        fbdsel_q       <= sel_encode(fb_raw_s);
        odsel_q        <= sel_encode(od_raw_s);
        pll_rst_q      <= 1'b1;
        locked_q       <= 1'b0;
        video_resetn_q <= 1'b0;
        mode_ready_q   <= 1'b0;
        if (req_good_s) begin
          mode_cur_q <= mode_sel;
          retry_q    <= '0;
          fault_q    <= 1'b0;
        end else if (state_q == ST_WAIT_LOCK) begin
          retry_q <= retry_d;
        end else begin
          retry_q <= retry_q;
        end
      end else begin
        case (state_q)
          ST_RESET_HOLD: begin
            if (rst_cnt_q == RST_LAST) begin
              state_q    <= ST_WAIT_LOCK;
              pll_rst_q  <= 1'b0;
              filt_cnt_q <= '0;
              tmo_cnt_q  <= '0;
            end else begin
              rst_cnt_q <= rst_cnt_d;
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_done_s) begin
              state_q        <= ST_LOCKED;
              locked_q       <= 1'b1;
              video_resetn_q <= 1'b1;
              mode_ready_q   <= 1'b1;
              retry_q        <= '0;
            end else if (tmo_done_s) begin
              // Retries exhausted: park with the PLL held in reset
              state_q      <= ST_FAULT;
              retry_q      <= retry_d;
              pll_rst_q    <= 1'b1;
              fault_q      <= 1'b1;
              mode_ready_q <= 1'b1;
            end else begin
              filt_cnt_q <= lock_s ? filt_cnt_d : '0;
              tmo_cnt_q  <= tmo_cnt_d;
            end
          end
          ST_LOCKED: begin
            state_q <= ST_LOCKED;
          end
          ST_FAULT: begin
            state_q <= ST_FAULT;
          end
          default: begin
            state_q   <= ST_RESET_HOLD;
            rst_cnt_q <= '0;
            pll_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pll_rst      = pll_rst_q;
  assign pll_idsel    = idsel_q;
  assign pll_fbdsel   = fbdsel_q;
  assign pll_odsel    = odsel_q;
  assign mode_ready   = mode_ready_q;
  assign mode_cur     = mode_cur_q;
  assign mode_err     = mode_err_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign video_resetn = video_resetn_q;

endmodule
